wb_stage: RTL and testbench

Write-back stage of the five-stage pipeline, directly downstream of the memory stage. It holds the MEM/WB pipeline register, with stall and flush control, and captures the ALU result, the raw data-memory read word and the write-back control bits. From the registered values it extracts and extends load data, then selects the register-file write data. It also keeps a retired-instruction counter for performance measurement.

---
 rtl/wb_stage.sv | 137 +++++++++++++
 tb/tb_wb_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load extraction/extension,
// register-file write data select and retired-instruction counter. WB_LOAD_EXT_EN enables sub-word loads.
module wb_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       WB,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rd,
  input  logic [31:0]      result,
  input  logic [31:0]      R_DATA,
  output logic             reg_write,
  output logic [4:0]       rd_out,
  output logic [31:0]      W_DATA,
  output logic [CNT_W-1:0] retired
);

  logic             valid_q, valid_d;
  logic             reg_wr_q, reg_wr_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      result_q, result_d;
  logic [31:0]      r_data_q, r_data_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             load_en;
  logic [31:0]      load_data;

  assign load_en = !flush && !stall;

  // Flush only kills the control bits; the data fields simply hold.
  always_comb begin
    valid_d      = valid_q;
    reg_wr_d     = reg_wr_q;
    mem_to_reg_d = mem_to_reg_q;
    rd_d         = rd_q;
    result_d     = result_q;
    r_data_d     = r_data_q;
    if (flush) begin
      valid_d      = 1'b0;
      reg_wr_d     = 1'b0;
      mem_to_reg_d = 1'b0;
    end else if (!stall) begin
      valid_d      = valid_in;
      reg_wr_d     = WB[1];
      mem_to_reg_d = WB[0];
      rd_d         = rd;
      result_d     = result;
      r_data_d     = R_DATA;
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (load_en && valid_in) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_wr_q     <= 1'b0;
      mem_to_reg_q <= 1'b0;
      rd_q         <= 5'd0;
      result_q     <= 32'd0;
      r_data_q     <= 32'd0;
      retired_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_wr_q     <= reg_wr_d;
      mem_to_reg_q <= mem_to_reg_d;
      rd_q         <= rd_d;
      result_q     <= result_d;
      r_data_q     <= r_data_d;
      retired_q    <= retired_d;
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [2:0]  funct3_q, funct3_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    funct3_d = funct3_q;
    if (load_en) begin
      funct3_d = funct3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q <= 3'd0;
    end else begin
      funct3_q <= funct3_d;
    end
  end

  always_comb begin
    byte_sel = r_data_q[7:0];
    unique case (result_q[1:0])
      2'b00: byte_sel = r_data_q[7:0];
      2'b01: byte_sel = r_data_q[15:8];
      2'b10: byte_sel = r_data_q[23:16];
      2'b11: byte_sel = r_data_q[31:24];
      default: byte_sel = r_data_q[7:0];
    endcase
    // Halfword lane comes from result[1] only; misaligned halves are not trapped.
    half_sel = result_q[1] ? r_data_q[31:16] : r_data_q[15:0];
  end

  always_comb begin
    load_data = r_data_q;
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = r_data_q;
    endcase
  end
`else
  logic unused_funct3;
  assign unused_funct3 = ^funct3;
  assign load_data     = r_data_q;
`endif

  assign reg_write = valid_q && reg_wr_q && (rd_q != 5'd0);
  assign rd_out    = rd_q;
  assign W_DATA    = mem_to_reg_q ? load_data : result_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a driver pushes expected register outputs, a monitor pops/compares.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb;
  logic        valid_in, stall, flush;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] result, r_data;
  logic        reg_write;
  logic [4:0]  rd_out;
  logic [31:0] w_data;
  logic [31:0] retired;
  logic        unused_rw4;
  logic [4:0]  unused_rd4;
  logic [31:0] unused_wd4;
  logic [3:0]  retired4;

  always #5 clk = ~clk;

  wb_stage #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .WB(wb), .valid_in(valid_in), .stall(stall), .flush(flush),
    .funct3(funct3), .rd(rd), .result(result), .R_DATA(r_data),
    .reg_write(reg_write), .rd_out(rd_out), .W_DATA(w_data), .retired(retired)
  );

  wb_stage #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .WB(wb), .valid_in(valid_in), .stall(stall), .flush(flush),
    .funct3(funct3), .rd(rd), .result(result), .R_DATA(r_data),
    .reg_write(unused_rw4), .rd_out(unused_rd4), .W_DATA(unused_wd4), .retired(retired4)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        care;
    logic [31:0] ret;
    logic [3:0]  ret4;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m;
  int unsigned cnt;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Applies one cycle of inputs; expected post-edge state is pushed at the edge.
  task automatic step(input logic r, input logic [1:0] w, input logic v, input logic s,
                      input logic f, input logic [2:0] f3, input logic [4:0] d,
                      input logic [31:0] res, input logic [31:0] rdat, input logic [31:0] exp_wd);
    logic [31:0] e_wd;
    rst = r; wb = w; valid_in = v; stall = s; flush = f;
    funct3 = f3; rd = d; result = res; r_data = rdat;
    e_wd = exp_wd;
`ifndef WB_LOAD_EXT_EN
    if (w[0]) e_wd = rdat;
`endif
    @(posedge clk);
    if (r) begin
      m.rw = 1'b0; m.rd = 5'd0; m.wd = 32'd0; m.care = 1'b1; cnt = 0;
    end else if (f) begin
      m.rw = 1'b0; m.care = 1'b0;
    end else if (!s) begin
      m.rw = v && w[1] && (d != 5'd0); m.rd = d; m.wd = e_wd; m.care = 1'b1;
      if (v) cnt++;
    end
    m.ret  = cnt;
    m.ret4 = cnt[3:0];
    exp_q.push_back(m);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("reg_write", {31'd0, reg_write}, {31'd0, e.rw});
        chk("retired", retired, e.ret);
        chk("retired_cnt4", {28'd0, retired4}, {28'd0, e.ret4});
        if (e.care) begin
          chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
          chk("W_DATA", w_data, e.wd);
        end
      end
    end
  end

  localparam logic [31:0] RD = 32'h80FF_7F01;

  initial begin : driver
    m = '{rw: 1'b0, rd: 5'd0, wd: 32'd0, care: 1'b0, ret: 32'd0, ret4: 4'd0};
    cnt = 0;
    // Reset then idle
    repeat (2) step(1, 2'b00, 0, 0, 0, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);
    repeat (5) step(0, 2'b00, 0, 0, 0, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);
    // ALU write-back
    step(0, 2'b10, 1, 0, 0, 3'b000, 5'd5, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_1234);
    // Loads from 0x80FF_7F01
    step(0, 2'b11, 1, 0, 0, 3'b000, 5'd1,  32'h1000_0003, RD, 32'hFFFF_FF80);
    step(0, 2'b11, 1, 0, 0, 3'b100, 5'd2,  32'h1000_0002, RD, 32'h0000_00FF);
    step(0, 2'b11, 1, 0, 0, 3'b001, 5'd3,  32'h1000_0002, RD, 32'hFFFF_80FF);
    step(0, 2'b11, 1, 0, 0, 3'b101, 5'd4,  32'h1000_0000, RD, 32'h0000_7F01);
    step(0, 2'b11, 1, 0, 0, 3'b000, 5'd6,  32'h1000_0001, RD, 32'h0000_007F);
    step(0, 2'b11, 1, 0, 0, 3'b001, 5'd8,  32'h1000_0001, RD, 32'h0000_7F01);
    step(0, 2'b11, 1, 0, 0, 3'b101, 5'd9,  32'h1000_0003, RD, 32'h0000_80FF);
    step(0, 2'b11, 1, 0, 0, 3'b010, 5'd10, 32'h1000_0000, RD, 32'h80FF_7F01);
    step(0, 2'b11, 1, 0, 0, 3'b011, 5'd11, 32'h1000_0002, RD, 32'h80FF_7F01);
    step(0, 2'b11, 1, 0, 0, 3'b100, 5'd12, 32'h1000_0000, RD, 32'h0000_0001);
    // x0 suppression, then an invalid slot
    step(0, 2'b10, 1, 0, 0, 3'b000, 5'd0,  32'h0000_0055, 32'd0, 32'h0000_0055);
    step(0, 2'b10, 0, 0, 0, 3'b000, 5'd13, 32'h0000_0066, 32'd0, 32'h0000_0066);
    // Stall for 3 cycles with changing inputs
    step(0, 2'b10, 1, 0, 0, 3'b000, 5'd7,  32'h0000_0077, 32'd0, 32'h0000_0077);
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b11, 1, 1, 0, 3'b000, 5'(20 + i), 32'hA000_0000 + i, RD, 32'd0);
    end
    // Flush, reload, then stall+flush together
    step(0, 2'b10, 1, 0, 1, 3'b000, 5'd14, 32'h0000_0014, 32'd0, 32'd0);
    step(0, 2'b10, 1, 0, 0, 3'b000, 5'd15, 32'h0000_0015, 32'd0, 32'h0000_0015);
    step(0, 2'b10, 1, 1, 1, 3'b000, 5'd17, 32'h0000_0017, 32'd0, 32'd0);
    step(0, 2'b10, 1, 0, 0, 3'b000, 5'd16, 32'h0000_0016, 32'd0, 32'h0000_0016);
    // Reset while stalling and flushing
    step(1, 2'b10, 1, 1, 1, 3'b000, 5'd18, 32'h0000_0018, 32'd0, 32'd0);
    // 17 valid instructions: 4-bit counter wraps to 1
    for (int i = 1; i <= 17; i++) begin
      step(0, 2'b10, 1, 0, 0, 3'b000, 5'(i), 32'(i * 3), 32'd0, 32'(i * 3));
    end
    step(0, 2'b00, 0, 0, 0, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
